// File: rtl/axis_iter_divider.sv
// axis_iter_divider: AXI-Stream radix-2 restoring divider.
// Dividend and divisor arrive on independent slave channels. Once both are
// held, one quotient bit is produced per cycle, MSB first.
// {quotient, remainder} is returned on a master channel with backpressure.
// Latency from the edge that captures the second operand to tvalid is
// WIDTH+1 edges: one setup cycle plus WIDTH iterations.

module axis_iter_divider #(
    parameter int WIDTH  = 32,
    parameter bit SIGNED = 1'b1
) (
    input  logic               aclk,
    input  logic               aresetn,

    input  logic [WIDTH-1:0]   s_axis_dividend_tdata,
    input  logic               s_axis_dividend_tvalid,
    output logic               s_axis_dividend_tready,

    input  logic [WIDTH-1:0]   s_axis_divisor_tdata,
    input  logic               s_axis_divisor_tvalid,
    output logic               s_axis_divisor_tready,

    output logic [2*WIDTH-1:0] m_axis_dout_tdata,
    output logic               m_axis_dout_tuser,
    output logic               m_axis_dout_tvalid,
    input  logic               m_axis_dout_tready
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_next;

    // Operand holding registers and their occupancy flags
    logic [WIDTH-1:0] dvd_hold, dvs_hold;
    logic             dvd_full, dvs_full;
    logic             dvd_full_next, dvs_full_next;
    logic             dvd_ready, dvs_ready;
    logic             dvd_fire, dvs_fire, out_fire;

    // Iteration state
    logic             primed;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] q_work, r_work, dvs_mag;
    logic             qneg, rneg, div0;

    // Per-iteration combinational values
    logic [WIDTH:0]   shifted;
    logic             fits;
    logic [WIDTH-1:0] diff, q_next, r_next;
    logic [WIDTH-1:0] quot_final, rem_final;
    logic             dvd_neg, dvs_neg;

    assign dvd_fire = s_axis_dividend_tvalid & dvd_ready;
    assign dvs_fire = s_axis_divisor_tvalid  & dvs_ready;
    assign out_fire = m_axis_dout_tvalid & m_axis_dout_tready;

    // A result handshake empties both holding registers; otherwise a
    // channel handshake fills its own register.
    assign dvd_full_next = out_fire ? 1'b0 : (dvd_full | dvd_fire);
    assign dvs_full_next = out_fire ? 1'b0 : (dvs_full | dvs_fire);

    assign s_axis_dividend_tready = dvd_ready;
    assign s_axis_divisor_tready  = dvs_ready;

    assign dvd_neg = SIGNED && dvd_hold[WIDTH-1];
    assign dvs_neg = SIGNED && dvs_hold[WIDTH-1];

    // State register
    always_ff @(posedge aclk or negedge aresetn) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values; blocking here would create order-dependent races.
        if (!aresetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        // NOTE: assign a default before the case so no path leaves state_next
        // unassigned, which would otherwise infer a latch.
        state_next = state;
        case (state)
            IDLE: if (dvd_full_next && dvs_full_next) state_next = CALC;
            CALC: if (primed && (count == '0))        state_next = DONE;
            DONE: if (out_fire)                       state_next = IDLE;
            default:                                  state_next = IDLE;
        endcase
    end

    // Output logic: the result is valid exactly while in DONE
    always_comb begin
        m_axis_dout_tvalid = (state == DONE);
    end

    // Operand capture; each channel handshakes independently while idle
    always_ff @(posedge aclk or negedge aresetn) begin
        // NOTE: the data registers are reset as well as the flags, so nothing
        // from a discarded operation can ever feed the datapath after reset.
        if (!aresetn) begin
            dvd_hold <= '0;
            dvs_hold <= '0;
            dvd_full <= 1'b0;
            dvs_full <= 1'b0;
        end else begin
            dvd_full <= dvd_full_next;
            dvs_full <= dvs_full_next;
            if (dvd_fire) dvd_hold <= s_axis_dividend_tdata;
            if (dvs_fire) dvs_hold <= s_axis_divisor_tdata;
        end
    end

    // Registered treadys: low in reset, high only when idle with an empty slot
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            dvd_ready <= 1'b0;
            dvs_ready <= 1'b0;
        end else begin
            dvd_ready <= (state_next == IDLE) && !dvd_full_next;
            dvs_ready <= (state_next == IDLE) && !dvs_full_next;
        end
    end

    // One restoring step: shift in the next dividend bit and subtract if it fits.
    // The shifted value is WIDTH+1 bits wide, so the unsigned magnitude of the
    // most negative dividend needs no special handling.
    always_comb begin
        shifted = {r_work, q_work[WIDTH-1]};
        fits    = (shifted >= {1'b0, dvs_mag});
        diff    = shifted[WIDTH-1:0] - dvs_mag;
        r_next  = fits ? diff : shifted[WIDTH-1:0];
        q_next  = {q_work[WIDTH-2:0], fits};
    end

    // Sign restoration and the divide-by-zero override applied to the final step
    always_comb begin
        quot_final = qneg ? (~q_next + 1'b1) : q_next;
        rem_final  = rneg ? (~r_next + 1'b1) : r_next;
        if (div0) begin
            quot_final = '1;
            rem_final  = dvd_hold;
        end
    end

    // Iteration datapath: setup on the first CALC cycle, then WIDTH steps
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            primed  <= 1'b0;
            count   <= '0;
            q_work  <= '0;
            r_work  <= '0;
            dvs_mag <= '0;
            qneg    <= 1'b0;
            rneg    <= 1'b0;
            div0    <= 1'b0;
        end else if (state == CALC) begin
            if (!primed) begin
                primed  <= 1'b1;
                count   <= CW'(WIDTH - 1);
                q_work  <= dvd_neg ? (~dvd_hold + 1'b1) : dvd_hold;
                r_work  <= '0;
                dvs_mag <= dvs_neg ? (~dvs_hold + 1'b1) : dvs_hold;
                qneg    <= dvd_neg ^ dvs_neg;
                rneg    <= dvd_neg;
                div0    <= (dvs_hold == '0);
            end else begin
                q_work  <= q_next;
                r_work  <= r_next;
                count   <= count - CW'(1);
            end
        end else begin
            primed <= 1'b0;
        end
    end

    // Result register: loaded on the CALC->DONE edge, held through backpressure
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            m_axis_dout_tdata <= '0;
            m_axis_dout_tuser <= 1'b0;
        end else if ((state == CALC) && (state_next == DONE)) begin
            m_axis_dout_tdata <= {quot_final, rem_final};
            m_axis_dout_tuser <= div0;
        end
    end

endmodule
